// File: rtl/alu_pkg.sv
// Shared ALU definitions: divider FSM states and default sizing.
package alu_pkg;

  localparam int DIV_WIDTH = 8;
  localparam int DIV_CNT_W = $clog2(DIV_WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } div_state_t;

endpackage

// File: rtl/divider_div_step.sv
// One combinational restoring-division step: shift {R,Q} left, trial-subtract D.
module div_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH:0]   r,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH:0]   r_next,
  output logic [WIDTH-1:0] q_next
);

  // The shifted remainder keeps R's top bit so the trial difference has room
  // for a borrow bit above the WIDTH+1 remainder bits.
  logic [WIDTH+1:0] r_shift;
  logic [WIDTH+1:0] diff;
  logic             borrow;

  // Trial subtraction; restore (keep shifted R) when it would go negative.
  always_comb begin
    r_shift = {r, q[WIDTH-1]};
    diff    = r_shift - {2'b00, d};
    borrow  = diff[WIDTH+1];
    if (borrow) begin
      r_next = r_shift[WIDTH:0];
      q_next = {q[WIDTH-2:0], 1'b0};
    end else begin
      r_next = diff[WIDTH:0];
      q_next = {q[WIDTH-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/divider.sv
// Multi-cycle unsigned restoring divider with START/DONE handshake.
module divider
  import alu_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             START,
  input  logic [WIDTH-1:0] INPUT1,
  input  logic [WIDTH-1:0] INPUT2,
  output logic [WIDTH-1:0] QUOTIENT,
  output logic [WIDTH-1:0] REMAINDER,
  output logic             BUSY,
  output logic             DONE,
  output logic             DIV_BY_ZERO
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  div_state_t       state, state_next;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH:0]   rem_w, rem_n;
  logic [WIDTH-1:0] quo_w, quo_n;
  logic [WIDTH-1:0] dvs;
  logic             accept;
  logic             zero_div;
  logic             last_step;

  assign accept    = (state == IDLE) && START;
  assign zero_div  = (INPUT2 == '0);
  assign last_step = (state == RUN) && (cnt == CNT_W'(WIDTH - 1));

  // BUSY and DONE decode the state register, so they never coincide.
  assign BUSY = (state == RUN);
  assign DONE = (state == FINISH);

  div_step #(.WIDTH(WIDTH)) u_step (
    .r      (rem_w),
    .q      (quo_w),
    .d      (dvs),
    .r_next (rem_n),
    .q_next (quo_n)
  );

  // State register.
  always_ff @(posedge CLK) begin
    if (!RESET) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic; a divisor of zero skips straight to FINISH.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (START) state_next = zero_div ? FINISH : RUN;
      RUN:     if (last_step) state_next = FINISH;
      FINISH:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Step counter: cleared on accept, advanced once per RUN cycle.
  always_ff @(posedge CLK) begin
    if (!RESET)            cnt <= '0;
    else if (accept)       cnt <= '0;
    else if (state == RUN) cnt <= cnt + 1'b1;
  end

  // Working registers: operands latched on accept, then iterated in RUN.
  always_ff @(posedge CLK) begin
    if (accept) begin
      dvs   <= INPUT2;
      quo_w <= INPUT1;
      rem_w <= '0;
    end else if (state == RUN) begin
      rem_w <= rem_n;
      quo_w <= quo_n;
    end
  end

  // Result registers: written only on the edge entering FINISH, held otherwise.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      QUOTIENT    <= '0;
      REMAINDER   <= '0;
      DIV_BY_ZERO <= 1'b0;
    end else if (accept && zero_div) begin
      QUOTIENT    <= '1;
      REMAINDER   <= INPUT1;
      DIV_BY_ZERO <= 1'b1;
    end else if (last_step) begin
      QUOTIENT    <= quo_n;
      REMAINDER   <= rem_n[WIDTH-1:0];
      DIV_BY_ZERO <= 1'b0;
    end
  end

endmodule

// File: tb/tb_divider.sv
// Directed and randomized bench for the restoring divider.
module tb_divider;

  localparam int W = 8;

  logic         CLK = 1'b0;
  logic         RESET = 1'b0;
  logic         START = 1'b0;
  logic [W-1:0] INPUT1 = '0;
  logic [W-1:0] INPUT2 = '0;
  logic [W-1:0] QUOTIENT, REMAINDER;
  logic         BUSY, DONE, DIV_BY_ZERO;

  int vectors = 0;
  int miscompares = 0;

  divider #(.WIDTH(W)) dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .START       (START),
    .INPUT1      (INPUT1),
    .INPUT2      (INPUT2),
    .QUOTIENT    (QUOTIENT),
    .REMAINDER   (REMAINDER),
    .BUSY        (BUSY),
    .DONE        (DONE),
    .DIV_BY_ZERO (DIV_BY_ZERO)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer division with the zero-divisor convention.
  function automatic logic [W-1:0] ref_q(input logic [W-1:0] a, input logic [W-1:0] b);
    return (b == 0) ? {W{1'b1}} : W'(a / b);
  endfunction

  function automatic logic [W-1:0] ref_r(input logic [W-1:0] a, input logic [W-1:0] b);
    return (b == 0) ? a : W'(a % b);
  endfunction

  task automatic chk_idle_zero(input string tag);
    chk({tag, "_q"},    QUOTIENT, 0);
    chk({tag, "_r"},    REMAINDER, 0);
    chk({tag, "_busy"}, BUSY, 0);
    chk({tag, "_done"}, DONE, 0);
    chk({tag, "_dbz"},  DIV_BY_ZERO, 0);
  endtask

  // One divide: accept, per-cycle BUSY/DONE, results on DONE, hold afterwards.
  // inject_at > 0 drives a stray START so it is sampled at edge t<inject_at>.
  // reset_at > 0 asserts reset at edge t<reset_at> and ends the transaction.
  task automatic run_div(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input int inject_at, input int reset_at);
    int steps;
    logic [W-1:0] eq, er;
    steps = (b == 0) ? 0 : W;
    eq = ref_q(a, b);
    er = ref_r(a, b);
    @(negedge CLK);
    INPUT1 = a; INPUT2 = b; START = 1'b1;
    @(posedge CLK);
    for (int k = 0; k < steps; k++) begin
      @(negedge CLK);
      START = 1'b0;
      INPUT1 = W'($urandom); INPUT2 = W'($urandom);
      chk({tag, "_busy"}, BUSY, 1);
      chk({tag, "_done_early"}, DONE, 0);
      if (k + 1 == inject_at) begin
        START = 1'b1; INPUT1 = 8'd50; INPUT2 = 8'd5;
      end
      if (k + 1 == reset_at) RESET = 1'b0;
      @(posedge CLK);
      if (k + 1 == reset_at) begin
        @(negedge CLK);
        RESET = 1'b1;
        chk_idle_zero({tag, "_rst"});
        return;
      end
    end
    @(negedge CLK);
    START = 1'b0;
    chk({tag, "_done"}, DONE, 1);
    chk({tag, "_busy_at_done"}, BUSY, 0);
    chk({tag, "_q"}, QUOTIENT, eq);
    chk({tag, "_r"}, REMAINDER, er);
    chk({tag, "_dbz"}, DIV_BY_ZERO, (b == 0));
    @(posedge CLK);
    @(negedge CLK);
    chk({tag, "_done_fall"}, DONE, 0);
    chk({tag, "_busy_after"}, BUSY, 0);
    chk({tag, "_q_hold"}, QUOTIENT, eq);
    chk({tag, "_r_hold"}, REMAINDER, er);
  endtask

  initial begin
    logic [W-1:0] ra, rb;

    // Reset and check all outputs clear.
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk_idle_zero("reset");
    RESET = 1'b1;

    run_div("d100_7", 8'd100, 8'd7, 0, 0);
    run_div("dbz5", 8'd5, 8'd0, 0, 0);
    run_div("d255_1", 8'd255, 8'd1, 0, 0);
    run_div("d3_10", 8'd3, 8'd10, 0, 0);
    run_div("d255_255", 8'd255, 8'd255, 0, 0);
    run_div("d0_9", 8'd0, 8'd9, 0, 0);

    // Stray START in RUN is ignored; results persist while idle.
    run_div("ign200_3", 8'd200, 8'd3, 3, 0);
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("hold_q", QUOTIENT, 66);
    chk("hold_r", REMAINDER, 2);

    // Reset in the middle of RUN, then a fresh divide.
    run_div("rst200_3", 8'd200, 8'd3, 0, 4);
    run_div("d50_5", 8'd50, 8'd5, 0, 0);

    // START held high: second request accepted once back in IDLE.
    @(negedge CLK);
    INPUT1 = 8'd100; INPUT2 = 8'd7; START = 1'b1;
    @(posedge CLK);
    for (int k = 0; k < W; k++) begin
      @(negedge CLK);
      chk("b2b1_busy", BUSY, 1);
      if (k == W - 1) begin INPUT1 = 8'd81; INPUT2 = 8'd9; end
      @(posedge CLK);
    end
    @(negedge CLK);
    chk("b2b1_done", DONE, 1);
    chk("b2b1_q", QUOTIENT, 14);
    chk("b2b1_r", REMAINDER, 2);
    @(posedge CLK);
    @(negedge CLK);
    chk("b2b_gap_busy", BUSY, 0);
    chk("b2b_gap_done", DONE, 0);
    @(posedge CLK);
    for (int k = 0; k < W; k++) begin
      @(negedge CLK);
      START = 1'b0;
      chk("b2b2_busy", BUSY, 1);
      @(posedge CLK);
    end
    @(negedge CLK);
    chk("b2b2_done", DONE, 1);
    chk("b2b2_q", QUOTIENT, 9);
    chk("b2b2_r", REMAINDER, 0);

    // Randomized operands, with an occasional zero divisor.
    for (int i = 0; i < 30; i++) begin
      ra = W'($urandom);
      rb = ($urandom_range(0, 7) == 0) ? 8'd0 : W'($urandom_range(1, 255));
      run_div("rand", ra, rb, 0, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
